// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle ARM controller (master) and its datapath (slave).
interface multicycle_controller_if;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic        MemReady;
    logic        PCWrite;
    logic        AdrSrc;
    logic        MemWrite;
    logic        IRWrite;
    logic        RegWrite;
    logic [1:0]  RegSrc;
    logic [1:0]  ImmSrc;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [2:0]  ALUControl;
    logic [1:0]  ResultSrc;
    logic        LinkWrite;
    logic [3:0]  Flags;
    logic [3:0]  State;

    modport master (
        input  Instr, ALUFlags, MemReady,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, RegSrc, ImmSrc,
               ALUSrcA, ALUSrcB, ALUControl, ResultSrc, LinkWrite, Flags, State
    );

    modport slave (
        output Instr, ALUFlags, MemReady,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, RegSrc, ImmSrc,
               ALUSrcA, ALUSrcB, ALUControl, ResultSrc, LinkWrite, Flags, State
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle ARMv4-subset control FSM: sequences ALU, unified memory, register file and PC/IR,
// owns NZCV flags and conditional-execution gating.
//
// state  | meaning
// FETCH  | read instruction at PC, PC <= PC+4 when memory ready
// DECODE | read registers, latch condition result
// MEMADR | ALUOut <= Rn + imm12
// MEMRD  | read data memory at ALUOut
// MEMWB  | write loaded data to Rd
// MEMWR  | write Rd to memory at ALUOut
// EXECR  | ALU on register operand
// EXECI  | ALU on imm8 operand
// ALUWB  | write ALUOut to Rd, commit flags
// BRANCH | PC <= PC+8+imm24<<2, optional link
// ERR    | unsupported op or fetch timeout; left only by reset
module multicycle_controller #(
    parameter int FETCH_TIMEOUT = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    multicycle_controller_if.master bus
);
    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXECR  = 4'd6;
    localparam logic [3:0] S_EXECI  = 4'd7;
    localparam logic [3:0] S_ALUWB  = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;
    localparam logic [3:0] S_ERR    = 4'd15;

    localparam int CW = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT + 1) : 1;

    logic [3:0]    state, state_next;
    logic [3:0]    cond, rd;
    logic [1:0]    op;
    logic [5:0]    funct;
    logic          cond_ex, cond_ex_r;
    logic [3:0]    flags, flags_cap;
    logic [2:0]    alu_ctrl;
    logic          alu_bad, alu_arith;
    logic [CW-1:0] wait_cnt;
    logic          fetch_tmo;
    logic          unused_rn;

    assign cond      = bus.Instr[19:16];
    assign op        = bus.Instr[15:14];
    assign funct     = bus.Instr[13:8];
    assign rd        = bus.Instr[3:0];
    assign unused_rn = ^bus.Instr[7:4];

    assign bus.Flags = flags;
    assign bus.State = state;

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            4'b0000: cond_ex = flags[2];
            4'b0001: cond_ex = ~flags[2];
            4'b0010: cond_ex = flags[1];
            4'b0011: cond_ex = ~flags[1];
            4'b0100: cond_ex = flags[3];
            4'b0101: cond_ex = ~flags[3];
            4'b0110: cond_ex = flags[0];
            4'b0111: cond_ex = ~flags[0];
            4'b1000: cond_ex = flags[1] & ~flags[2];
            4'b1001: cond_ex = ~flags[1] | flags[2];
            4'b1010: cond_ex = (flags[3] == flags[0]);
            4'b1011: cond_ex = (flags[3] != flags[0]);
            4'b1100: cond_ex = ~flags[2] & (flags[3] == flags[0]);
            4'b1101: cond_ex = flags[2] | (flags[3] != flags[0]);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    always_comb begin
        alu_ctrl = 3'b000;
        alu_bad  = 1'b0;
        case (funct[4:1])
            4'b0100, 4'b1011: alu_ctrl = 3'b000;
            4'b0010, 4'b1010: alu_ctrl = 3'b001;
            4'b0000, 4'b1000: alu_ctrl = 3'b010;
            4'b1100:          alu_ctrl = 3'b011;
            4'b0001, 4'b1001: alu_ctrl = 3'b111;
            4'b1110:          alu_ctrl = 3'b110;
            4'b1111:          alu_ctrl = 3'b100;
            default:          alu_bad  = 1'b1;
        endcase
        alu_arith = ~alu_bad & ((alu_ctrl == 3'b000) | (alu_ctrl == 3'b001));
    end

    // Timeout fires on the FETCH_TIMEOUT-th consecutive not-ready fetch cycle.
    assign fetch_tmo = (FETCH_TIMEOUT > 0) && !bus.MemReady &&
                       (wait_cnt == CW'(FETCH_TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_FETCH;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags     <= 4'b0000;
            flags_cap <= 4'b0000;
            cond_ex_r <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            if (state == S_FETCH && !bus.MemReady) wait_cnt <= wait_cnt + 1'b1;
            else                                   wait_cnt <= '0;
            if (state == S_DECODE) cond_ex_r <= cond_ex;
            if (state == S_EXECR || state == S_EXECI) flags_cap <= bus.ALUFlags;
            // Logic ops leave C and V untouched; only add/sub produce meaningful carry/overflow.
            if (state == S_ALUWB && funct[0] && cond_ex_r) begin
                flags[3:2] <= flags_cap[3:2];
                if (alu_arith) flags[1:0] <= flags_cap[1:0];
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH: begin
                if (bus.MemReady)   state_next = S_DECODE;
                else if (fetch_tmo) state_next = S_ERR;
            end
            S_DECODE: begin
                case (op)
                    2'b01:   state_next = S_MEMADR;
                    2'b00:   state_next = funct[5] ? S_EXECI : S_EXECR;
                    2'b10:   state_next = S_BRANCH;
                    default: state_next = S_FETCH;
                endcase
            end
            S_MEMADR: state_next = funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (bus.MemReady) state_next = S_MEMWB;
            S_MEMWB:  state_next = S_FETCH;
            S_MEMWR:  if (bus.MemReady || !cond_ex_r) state_next = S_FETCH;
            S_EXECR, S_EXECI: state_next = alu_bad ? S_ERR : S_ALUWB;
            S_ALUWB:  state_next = S_FETCH;
            S_BRANCH: state_next = S_FETCH;
            S_ERR:    state_next = S_ERR;
            default:  state_next = S_ERR;
        endcase
    end

    always_comb begin
        bus.PCWrite    = 1'b0;
        bus.AdrSrc     = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.RegWrite   = 1'b0;
        bus.RegSrc     = 2'b00;
        bus.ImmSrc     = 2'b00;
        bus.ALUSrcA    = 1'b0;
        bus.ALUSrcB    = 2'b00;
        bus.ALUControl = 3'b000;
        bus.ResultSrc  = 2'b00;
        bus.LinkWrite  = 1'b0;
        case (state)
            S_FETCH: begin
                bus.ALUSrcA   = 1'b1;
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
                bus.IRWrite   = bus.MemReady;
                bus.PCWrite   = bus.MemReady;
            end
            S_DECODE: begin
                bus.ALUSrcA   = 1'b1;
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
            end
            S_MEMADR: begin
                bus.ALUSrcB = 2'b01;
                bus.ImmSrc  = 2'b01;
            end
            S_MEMRD: bus.AdrSrc = 1'b1;
            S_MEMWB: begin
                bus.ResultSrc = 2'b01;
                bus.RegWrite  = cond_ex_r;
                bus.PCWrite   = cond_ex_r & (rd == 4'd15);
            end
            S_MEMWR: begin
                bus.AdrSrc   = 1'b1;
                bus.RegSrc   = 2'b10;
                bus.MemWrite = cond_ex_r;
            end
            S_EXECR: bus.ALUControl = alu_ctrl;
            S_EXECI: begin
                bus.ALUSrcB    = 2'b01;
                bus.ALUControl = alu_ctrl;
            end
            S_ALUWB: begin
                bus.RegWrite = cond_ex_r & (funct[4:3] != 2'b10);
                bus.PCWrite  = cond_ex_r & (funct[4:3] != 2'b10) & (rd == 4'd15);
            end
            S_BRANCH: begin
                bus.RegSrc    = 2'b01;
                bus.ALUSrcB   = 2'b01;
                bus.ImmSrc    = 2'b10;
                bus.ResultSrc = 2'b10;
                bus.PCWrite   = cond_ex_r;
                bus.LinkWrite = cond_ex_r & funct[4];
            end
            default: ;
        endcase
        // Reset must kill every write strobe immediately, not at the next clock.
        if (!reset) begin
            bus.PCWrite   = 1'b0;
            bus.IRWrite   = 1'b0;
            bus.RegWrite  = 1'b0;
            bus.MemWrite  = 1'b0;
            bus.LinkWrite = 1'b0;
        end
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: instruction sequences with hand-computed per-cycle expectations.
module tb_multicycle_controller;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    multicycle_controller_if bus();

    multicycle_controller #(.FETCH_TIMEOUT(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic mr, input logic [3:0] af);
        @(negedge clk);
        bus.MemReady = mr;
        bus.ALUFlags = af;
        #1;
    endtask

    task automatic fetch(input string tag, input logic [19:0] ins);
        @(negedge clk);
        bus.Instr    = ins;
        bus.MemReady = 1'b1;
        bus.ALUFlags = 4'h0;
        #1;
        check({tag, ".fetch_state"}, 32'(bus.State), 32'd0);
        check({tag, ".fetch_irwrite"}, 32'(bus.IRWrite), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.Instr    = 20'h0;
        bus.ALUFlags = 4'h0;
        bus.MemReady = 1'b1;
        #11;
        check("rst.state", 32'(bus.State), 32'd0);
        check("rst.flags", 32'(bus.Flags), 32'd0);
        check("rst.pcwrite", 32'(bus.PCWrite), 32'd0);
        check("rst.irwrite", 32'(bus.IRWrite), 32'd0);
        bus.MemReady = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        // ADD R1,R0,#5 : S=0, so the EXEC-cycle flags must not stick
        fetch("add", 20'hE2801);
        check("add.fetch_alusrcb", 32'(bus.ALUSrcB), 32'd2);
        cyc(1'b1, 4'h0);  check("add.dec", 32'(bus.State), 32'd1);
        cyc(1'b1, 4'hF);  check("add.exec", 32'(bus.State), 32'd7);
        check("add.exec_srcb", 32'(bus.ALUSrcB), 32'd1);
        check("add.exec_alu", 32'(bus.ALUControl), 32'd0);
        check("add.exec_regwr", 32'(bus.RegWrite), 32'd0);
        cyc(1'b1, 4'h0);  check("add.wb", 32'(bus.State), 32'd8);
        check("add.wb_regwr", 32'(bus.RegWrite), 32'd1);
        check("add.wb_pcwr", 32'(bus.PCWrite), 32'd0);

        // SUBS R2,R1,R1 with ALU reporting Z and C
        fetch("subs", 20'hE0512);
        check("add.flags", 32'(bus.Flags), 32'd0);
        cyc(1'b1, 4'h0);     check("subs.dec", 32'(bus.State), 32'd1);
        cyc(1'b1, 4'b0110);  check("subs.exec", 32'(bus.State), 32'd6);
        check("subs.exec_alu", 32'(bus.ALUControl), 32'd1);
        check("subs.exec_srcb", 32'(bus.ALUSrcB), 32'd0);
        cyc(1'b1, 4'h0);     check("subs.wb", 32'(bus.State), 32'd8);

        // BEQ taken (Z=1)
        fetch("beq", 20'h0AFFF);
        check("subs.flags", 32'(bus.Flags), 32'b0110);
        cyc(1'b1, 4'h0);  check("beq.dec", 32'(bus.State), 32'd1);
        cyc(1'b1, 4'h0);  check("beq.br", 32'(bus.State), 32'd9);
        check("beq.pcwr", 32'(bus.PCWrite), 32'd1);
        check("beq.immsrc", 32'(bus.ImmSrc), 32'd2);
        check("beq.link", 32'(bus.LinkWrite), 32'd0);
        check("beq.regsrc", 32'(bus.RegSrc), 32'd1);

        // ANDS R0,R0,R0: N,Z update from 1011, C,V keep 10 -> 1010
        fetch("ands", 20'hE0100);
        cyc(1'b1, 4'h0);     check("ands.dec", 32'(bus.State), 32'd1);
        cyc(1'b1, 4'b1011);  check("ands.alu", 32'(bus.ALUControl), 32'd2);
        cyc(1'b1, 4'h0);     check("ands.wb_regwr", 32'(bus.RegWrite), 32'd1);

        // Same BEQ with Z=0: not taken
        fetch("beqnt", 20'h0AFFF);
        check("ands.flags", 32'(bus.Flags), 32'b1010);
        cyc(1'b1, 4'h0);
        cyc(1'b1, 4'h0);  check("beqnt.br", 32'(bus.State), 32'd9);
        check("beqnt.pcwr", 32'(bus.PCWrite), 32'd0);
        check("beqnt.link", 32'(bus.LinkWrite), 32'd0);

        // CMP R1,#5 with N=1 beforehand
        fetch("cmp", 20'hE3510);
        cyc(1'b1, 4'h0);
        cyc(1'b1, 4'b0110);  check("cmp.exec", 32'(bus.State), 32'd7);
        check("cmp.alu", 32'(bus.ALUControl), 32'd1);
        cyc(1'b1, 4'h0);     check("cmp.wb", 32'(bus.State), 32'd8);
        check("cmp.regwr", 32'(bus.RegWrite), 32'd0);

        // STRNE with Z=1: no write, no wait
        fetch("strne", 20'h15803);
        check("cmp.flags", 32'(bus.Flags), 32'b0110);
        cyc(1'b0, 4'h0);  check("strne.dec", 32'(bus.State), 32'd1);
        cyc(1'b0, 4'h0);  check("strne.adr", 32'(bus.State), 32'd2);
        check("strne.immsrc", 32'(bus.ImmSrc), 32'd1);
        cyc(1'b0, 4'h0);  check("strne.wr", 32'(bus.State), 32'd5);
        check("strne.memwr", 32'(bus.MemWrite), 32'd0);
        check("strne.adrsrc", 32'(bus.AdrSrc), 32'd1);

        // LDR R3,[R0,#8] with two not-ready MEMRD cycles
        fetch("ldr", 20'hE5903);
        cyc(1'b1, 4'h0);  check("ldr.dec", 32'(bus.State), 32'd1);
        cyc(1'b1, 4'h0);  check("ldr.adr", 32'(bus.State), 32'd2);
        for (int i = 0; i < 3; i++) begin
            cyc(i == 2, 4'h0);
            check($sformatf("ldr.rd%0d", i), 32'(bus.State), 32'd3);
            check($sformatf("ldr.rd%0d_adr", i), 32'(bus.AdrSrc), 32'd1);
        end
        cyc(1'b1, 4'h0);  check("ldr.wb", 32'(bus.State), 32'd4);
        check("ldr.wb_regwr", 32'(bus.RegWrite), 32'd1);
        check("ldr.wb_res", 32'(bus.ResultSrc), 32'd1);
        check("ldr.wb_pcwr", 32'(bus.PCWrite), 32'd0);

        // BL always
        fetch("bl", 20'hEBFFF);
        cyc(1'b1, 4'h0);
        cyc(1'b1, 4'h0);  check("bl.br", 32'(bus.State), 32'd9);
        check("bl.pcwr", 32'(bus.PCWrite), 32'd1);
        check("bl.link", 32'(bus.LinkWrite), 32'd1);

        // NOP (op 11): DECODE straight back to FETCH
        fetch("nop", 20'hEC000);
        cyc(1'b1, 4'h0);  check("nop.dec", 32'(bus.State), 32'd1);

        // cond 1111 never executes
        fetch("nv", 20'hF2801);
        cyc(1'b1, 4'h0);
        cyc(1'b1, 4'h0);  check("nv.exec", 32'(bus.State), 32'd7);
        cyc(1'b1, 4'h0);  check("nv.wb", 32'(bus.State), 32'd8);
        check("nv.regwr", 32'(bus.RegWrite), 32'd0);

        // STR held by memory, then reset mid-write
        fetch("str", 20'hE5803);
        cyc(1'b0, 4'h0);
        cyc(1'b0, 4'h0);
        cyc(1'b0, 4'h0);  check("str.wr0", 32'(bus.State), 32'd5);
        check("str.memwr0", 32'(bus.MemWrite), 32'd1);
        cyc(1'b0, 4'h0);  check("str.wr1", 32'(bus.State), 32'd5);
        check("str.memwr1", 32'(bus.MemWrite), 32'd1);
        #1 reset = 1'b0;
        #1;
        check("strrst.state", 32'(bus.State), 32'd0);
        check("strrst.memwr", 32'(bus.MemWrite), 32'd0);
        check("strrst.flags", 32'(bus.Flags), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        fetch("post", 20'hE2801);
        check("post.pcwr", 32'(bus.PCWrite), 32'd1);
        cyc(1'b1, 4'h0);  check("post.dec", 32'(bus.State), 32'd1);
        cyc(1'b1, 4'h0);  check("post.exec", 32'(bus.State), 32'd7);
        cyc(1'b1, 4'h0);  check("post.wb", 32'(bus.State), 32'd8);

        // MOV is outside the supported set -> ERR, sticky until reset
        fetch("mov", 20'hE3A00);
        cyc(1'b1, 4'h0);
        cyc(1'b1, 4'h0);  check("mov.exec", 32'(bus.State), 32'd7);
        cyc(1'b1, 4'h0);  check("mov.err", 32'(bus.State), 32'd15);
        cyc(1'b1, 4'h0);  check("mov.err_hold", 32'(bus.State), 32'd15);
        check("mov.err_irwr", 32'(bus.IRWrite), 32'd0);
        bus.MemReady = 1'b0;
        reset = 1'b0;
        #1 check("mov.rst", 32'(bus.State), 32'd0);

        // Fetch timeout: release cycle is wait #1, loop cycles are waits #2..#8
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 7; i++) begin
            cyc(1'b0, 4'h0);
            check($sformatf("tmo.wait%0d", i + 2), 32'(bus.State), 32'd0);
        end
        cyc(1'b0, 4'h0);  check("tmo.err", 32'(bus.State), 32'd15);
        cyc(1'b1, 4'h0);  check("tmo.err_hold", 32'(bus.State), 32'd15);
        check("tmo.pcwr", 32'(bus.PCWrite), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
